// File: rtl/capture_mem_arbiter.sv
// capture_mem_arbiter: stages capture packets through a small FIFO into a
// single-port sample memory and arbitrates leftover memory cycles to host reads.
`default_nettype none

module capture_mem_arbiter #(
  parameter int PACKET_WIDTH = 32,
  parameter int ADDR_WIDTH   = 12,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    capture_start,
  input  logic                    capture_active,
  input  logic                    cap_wr_en,
  input  logic [PACKET_WIDTH-1:0] cap_data,
  output logic                    cap_page_full,
  input  logic                    rd_req,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_gnt,
  output logic                    rd_valid,
  output logic [PACKET_WIDTH-1:0] rd_data,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [PACKET_WIDTH-1:0] mem_wdata,
  input  logic [PACKET_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH:0]     fill_count,
  output logic                    overflow,
  output logic                    capture_done
);

  localparam int MEM_DEPTH = 1 << ADDR_WIDTH;
  localparam int FIFO_AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FIFO_CW   = FIFO_AW + 1;
  localparam int OCC_W     = ADDR_WIDTH + 2;

  localparam logic [FIFO_AW-1:0] FIFO_LAST = FIFO_AW'(FIFO_DEPTH - 1);
  localparam logic [FIFO_CW-1:0] FIFO_FULL = FIFO_CW'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0]   OCC_MAX   = OCC_W'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] FILL_MAX = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [PACKET_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0]      fifo_rd_ptr_q, fifo_wr_ptr_q;
  logic [FIFO_CW-1:0]      fifo_count_q;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q;
  logic [ADDR_WIDTH:0]     fill_count_q;
  logic                    overflow_q;
  logic                    page_full_q;
  logic                    rd_valid_q;

  logic                    session_start;
  logic                    in_session;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic [OCC_W-1:0]        occupancy;
  logic                    push;
  logic                    drop;
  logic                    pop;

  assign session_start = (state_q == S_IDLE) && capture_start;
  assign in_session    = (state_q == S_CAPTURE) || (state_q == S_DRAIN);
  assign fifo_empty    = (fifo_count_q == '0);
  assign fifo_full     = (fifo_count_q == FIFO_FULL);
  // Staged words count against capacity so memory can never be over-committed.
  assign occupancy     = OCC_W'(fill_count_q) + OCC_W'(fifo_count_q);
  assign push          = cap_wr_en && in_session && !fifo_full && (occupancy < OCC_MAX);
  assign drop          = cap_wr_en && in_session && !push;
  assign pop           = !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (capture_start)   state_d = S_CAPTURE;
      S_CAPTURE: if (!capture_active) state_d = S_DRAIN;
      S_DRAIN:   if (fifo_empty)      state_d = S_DONE;
      S_DONE:                         state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  // Writes always win the memory port; reads take idle cycles outside DRAIN.
  always_comb begin
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    rd_gnt       = 1'b0;
    capture_done = 1'b0;
    if (!reset) begin
      capture_done = (state_q == S_DONE);
      if (pop) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr_ptr_q;
        mem_wdata = fifo_mem_q[fifo_rd_ptr_q];
      end else if (rd_req && (state_q != S_DRAIN)) begin
        mem_en   = 1'b1;
        mem_addr = rd_addr;
        rd_gnt   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[fifo_wr_ptr_q] <= cap_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_rd_ptr_q <= '0;
      fifo_wr_ptr_q <= '0;
      fifo_count_q  <= '0;
      wr_ptr_q      <= '0;
      fill_count_q  <= '0;
      overflow_q    <= 1'b0;
      page_full_q   <= 1'b0;
      rd_valid_q    <= 1'b0;
    end else begin
      rd_valid_q <= rd_gnt;
      if (session_start) begin
        fifo_rd_ptr_q <= '0;
        fifo_wr_ptr_q <= '0;
        fifo_count_q  <= '0;
        wr_ptr_q      <= '0;
        fill_count_q  <= '0;
        overflow_q    <= 1'b0;
        page_full_q   <= 1'b0;
      end else begin
        if (push) begin
          fifo_wr_ptr_q <= (fifo_wr_ptr_q == FIFO_LAST) ? '0 : fifo_wr_ptr_q + 1'b1;
        end
        if (pop) begin
          fifo_rd_ptr_q <= (fifo_rd_ptr_q == FIFO_LAST) ? '0 : fifo_rd_ptr_q + 1'b1;
          wr_ptr_q      <= wr_ptr_q + 1'b1;
          if (fill_count_q != FILL_MAX) begin
            fill_count_q <= fill_count_q + 1'b1;
          end
        end
        if (push && !pop) begin
          fifo_count_q <= fifo_count_q + 1'b1;
        end else if (pop && !push) begin
          fifo_count_q <= fifo_count_q - 1'b1;
        end
        if (drop) begin
          overflow_q <= 1'b1;
        end
        if (occupancy >= OCC_MAX) begin
          page_full_q <= 1'b1;
        end
      end
    end
  end

  assign cap_page_full = page_full_q;
  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_valid_q ? mem_rdata : '0;
  assign fill_count    = fill_count_q;
  assign overflow      = overflow_q;

endmodule

`default_nettype wire
